// File: rtl/tx_state_machine.sv
// rtl/tx_state_machine.sv - 10G MAC TX frame sequencer: PRE, DATA, optional PAD, FCS, ERR, IFG.
// Short-frame padding (PAD state, start_pad) is built only when TX_PAD_EN is defined.
module tx_state_machine #(
    parameter int MAX_DATA   = 9014,
    parameter int IFG_CYCLES = 2
`ifdef TX_PAD_EN
    ,
    parameter int MIN_DATA   = 60
`endif
) (
    input  logic        txclk,
    input  logic        reset_n,
    input  logic        tx_enable,
    input  logic        inband_fcs,
    input  logic        link_fault,
    input  logic        tx_start,
    input  logic        tx_underrun,
    input  logic        data_last,
    input  logic [2:0]  last_bytes,
    input  logic        fcs_done,
    output logic        tx_ack,
    output logic        start_preamble,
    output logic        start_data,
    output logic        start_pad,
    output logic        start_fcs,
    output logic        transmitting,
    output logic        send_error,
    output logic        good_frame_sent,
    output logic        bad_frame_sent,
    output logic [15:0] frame_len
);

    typedef enum logic [6:0] {
        S_IDLE = 7'd1,
        S_PRE  = 7'd2,
        S_DATA = 7'd4,
        S_PAD  = 7'd8,
        S_FCS  = 7'd16,
        S_ERR  = 7'd32,
        S_IFG  = 7'd64
    } state_t;

    localparam logic [15:0] MAX_16 = 16'(MAX_DATA);
    localparam logic [15:0] IFG_16 = 16'(IFG_CYCLES);

    state_t      state_q;
    logic [15:0] byte_cnt_q;
    logic [15:0] ifg_cnt_q;
    logic [15:0] frame_len_q;
    logic        good_q;
    logic        bad_q;

    logic [3:0]  word_bytes;
    logic [16:0] data_sum;
    logic [15:0] data_cnt;
    logic [15:0] ifg_next;

    // Byte count after accepting the current data word, saturating at 16'hFFFF.
    always_comb begin
        word_bytes = 4'd8;
        if (data_last && (last_bytes != 3'd0)) begin
            word_bytes = {1'b0, last_bytes};
        end
        data_sum = {1'b0, byte_cnt_q} + {13'd0, word_bytes};
        data_cnt = data_sum[16] ? 16'hFFFF : data_sum[15:0];
        ifg_next = ifg_cnt_q + 16'd1;
    end

`ifdef TX_PAD_EN
    localparam logic [15:0] MIN_16 = 16'(MIN_DATA);
    localparam logic [16:0] MIN_17 = 17'(MIN_DATA);

    logic [16:0] pad_sum;
    logic [15:0] pad_cnt;
    logic        pad_done;

    always_comb begin
        pad_sum  = {1'b0, byte_cnt_q} + 17'd8;
        pad_done = (pad_sum >= MIN_17);
        pad_cnt  = pad_done ? MIN_16 : pad_sum[15:0];
    end
`endif

    always_ff @(posedge txclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            byte_cnt_q  <= 16'd0;
            ifg_cnt_q   <= 16'd0;
            frame_len_q <= 16'd0;
            good_q      <= 1'b0;
            bad_q       <= 1'b0;
        end else begin
            good_q <= 1'b0;
            bad_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    ifg_cnt_q <= 16'd0;
                    if (tx_start && tx_enable && !link_fault) begin
                        state_q <= S_PRE;
                    end
                end
                S_PRE: begin
                    byte_cnt_q <= 16'd0;
                    state_q    <= S_DATA;
                end
                S_DATA: begin
                    byte_cnt_q <= data_cnt;
                    if (tx_underrun || link_fault || (data_cnt > MAX_16)) begin
                        state_q <= S_ERR;
`ifdef TX_PAD_EN
                    end else if (data_last && !inband_fcs && (data_cnt < MIN_16)) begin
                        state_q <= S_PAD;
`endif
                    end else if (data_last && inband_fcs) begin
                        // Client already carried the FCS: the frame is complete here.
                        state_q     <= S_IFG;
                        good_q      <= 1'b1;
                        frame_len_q <= data_cnt;
                    end else if (data_last) begin
                        state_q <= S_FCS;
                    end
                end
`ifdef TX_PAD_EN
                S_PAD: begin
                    byte_cnt_q <= pad_cnt;
                    if (pad_done) begin
                        state_q <= S_FCS;
                    end
                end
`endif
                S_FCS: begin
                    if (link_fault) begin
                        state_q <= S_ERR;
                    end else if (fcs_done) begin
                        state_q     <= S_IFG;
                        good_q      <= 1'b1;
                        frame_len_q <= byte_cnt_q;
                    end
                end
                S_ERR: begin
                    state_q     <= S_IFG;
                    bad_q       <= 1'b1;
                    frame_len_q <= byte_cnt_q;
                end
                S_IFG: begin
                    ifg_cnt_q <= ifg_next;
                    if (ifg_next >= IFG_16) begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign tx_ack          = (state_q == S_PRE);
    assign start_preamble  = (state_q == S_PRE);
    assign start_data      = (state_q == S_DATA);
`ifdef TX_PAD_EN
    assign start_pad       = (state_q == S_PAD);
`else
    assign start_pad       = 1'b0;
`endif
    assign start_fcs       = (state_q == S_FCS);
    assign transmitting    = (state_q == S_PRE) || (state_q == S_DATA) ||
                             (state_q == S_PAD) || (state_q == S_FCS);
    assign send_error      = (state_q == S_ERR);
    assign good_frame_sent = good_q;
    assign bad_frame_sent  = bad_q;
    assign frame_len       = frame_len_q;

endmodule

// File: tb/tb_tx_state_machine.sv
// tb/tb_tx_state_machine.sv - scoreboard bench for tx_state_machine (default and TX_PAD_EN builds)
module tb_tx_state_machine;

    localparam int MAX_DATA   = 9014;
    localparam int IFG_CYCLES = 2;
    localparam int MIN_DATA   = 60;

    logic        txclk;
    logic        reset_n;
    logic        tx_enable;
    logic        inband_fcs;
    logic        link_fault;
    logic        tx_start;
    logic        tx_underrun;
    logic        data_last;
    logic [2:0]  last_bytes;
    logic        fcs_done;
    logic        tx_ack;
    logic        start_preamble;
    logic        start_data;
    logic        start_pad;
    logic        start_fcs;
    logic        transmitting;
    logic        send_error;
    logic        good_frame_sent;
    logic        bad_frame_sent;
    logic [15:0] frame_len;

    tx_state_machine dut (
        .txclk          (txclk),
        .reset_n        (reset_n),
        .tx_enable      (tx_enable),
        .inband_fcs     (inband_fcs),
        .link_fault     (link_fault),
        .tx_start       (tx_start),
        .tx_underrun    (tx_underrun),
        .data_last      (data_last),
        .last_bytes     (last_bytes),
        .fcs_done       (fcs_done),
        .tx_ack         (tx_ack),
        .start_preamble (start_preamble),
        .start_data     (start_data),
        .start_pad      (start_pad),
        .start_fcs      (start_fcs),
        .transmitting   (transmitting),
        .send_error     (send_error),
        .good_frame_sent(good_frame_sent),
        .bad_frame_sent (bad_frame_sent),
        .frame_len      (frame_len)
    );

    typedef struct {
        int len;
        int bad;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    int n_tests = 0;
    int n_fail  = 0;
    int n_pre   = 0;
    int n_ack   = 0;
    int n_data  = 0;
    int n_pad   = 0;
    int n_fcs   = 0;
    int n_err   = 0;
    int n_stat  = 0;

    initial begin
        txclk = 1'b0;
        forever #5 txclk = ~txclk;
    end

    task automatic check_eq(input string tag, input longint obs, input longint exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge txclk);
        #1;
    endtask

    always @(negedge txclk) begin
        if (reset_n) begin
            if (start_preamble) n_pre++;
            if (tx_ack)         n_ack++;
            if (start_data)     n_data++;
            if (start_pad)      n_pad++;
            if (start_fcs)      n_fcs++;
            if (send_error)     n_err++;
            if (good_frame_sent || bad_frame_sent) begin
                n_stat++;
                check_eq("status_expected", int'(sb.size() > 0), 1);
                if (sb.size() > 0) begin
                    mon_e = sb.pop_front();
                    check_eq("status_bad", bad_frame_sent, mon_e.bad);
                    check_eq("status_good", good_frame_sent, 1 - mon_e.bad);
                    check_eq("frame_len", frame_len, mon_e.len);
                end
            end
        end
    end

    // Reference model: walks the words the bench will present and predicts the outcome.
    task automatic model(input int n, input int lb, input int u, input int inband,
                         output int len, output int bad, output int words, output int pads);
        int cum;
        int b;
        cum   = 0;
        bad   = 0;
        pads  = 0;
        words = n;
        for (int i = 1; i <= n; i++) begin
            b = (i == n) ? ((lb == 0) ? 8 : lb) : 8;
            cum += b;
            if ((i == u) || (cum > MAX_DATA)) begin
                bad   = 1;
                words = i;
                break;
            end
        end
        len = cum;
`ifdef TX_PAD_EN
        if ((bad == 0) && (inband == 0) && (cum < MIN_DATA)) begin
            pads = (MIN_DATA - cum + 7) / 8;
            len  = MIN_DATA;
        end
`endif
    endtask

    task automatic run_frame(input int n, input int lb, input int u, input int inband,
                             input int fcs_wait, input int keep);
        exp_t e;
        int   words;
        int   pads;
        int   found;
        int   k;
        int   b_pre, b_ack, b_data, b_pad, b_fcs, b_err;
        model(n, lb, u, inband, e.len, e.bad, words, pads);
        sb.push_back(e);
        b_pre  = n_pre;
        b_ack  = n_ack;
        b_data = n_data;
        b_pad  = n_pad;
        b_fcs  = n_fcs;
        b_err  = n_err;
        inband_fcs = inband[0];
        tx_start   = 1'b1;
        found = 0;
        for (int c = 0; c < 20; c++) begin
            if (start_preamble) begin
                found = 1;
                break;
            end
            tick();
        end
        check_eq("pre_seen", found, 1);
        if (keep == 0) tx_start = 1'b0;
        tick();
        for (int i = 1; i <= n; i++) begin
            if (!start_data) break;
            data_last   = (i == n);
            last_bytes  = 3'(lb);
            tx_underrun = (i == u);
            tick();
        end
        data_last   = 1'b0;
        tx_underrun = 1'b0;
        last_bytes  = 3'd0;
        k = 0;
        found = 0;
        for (int c = 0; c < 200; c++) begin
            if (!(transmitting || send_error)) begin
                found = 1;
                break;
            end
            if (start_fcs) begin
                k++;
                fcs_done = (k > fcs_wait);
            end else begin
                fcs_done = 1'b0;
            end
            tick();
        end
        fcs_done = 1'b0;
        check_eq("frame_end_seen", found, 1);
        @(negedge txclk);
        #2;
        check_eq("pre_cycles", n_pre - b_pre, 1);
        check_eq("ack_pulses", n_ack - b_ack, 1);
        check_eq("data_cycles", n_data - b_data, words);
        check_eq("pad_cycles", n_pad - b_pad, pads);
        check_eq("fcs_cycles", n_fcs - b_fcs, ((e.bad != 0) || (inband != 0)) ? 0 : fcs_wait + 1);
        check_eq("err_cycles", n_err - b_err, e.bad);
        check_eq("sb_drained", sb.size(), 0);
    endtask

    initial begin
        int gap;
        int found;
        int stat0;
        int pre0;
        reset_n     = 1'b0;
        tx_enable   = 1'b1;
        inband_fcs  = 1'b0;
        link_fault  = 1'b0;
        tx_start    = 1'b0;
        tx_underrun = 1'b0;
        data_last   = 1'b0;
        last_bytes  = 3'd0;
        fcs_done    = 1'b0;
        repeat (3) tick();
        check_eq("rst_outputs", {tx_ack, start_preamble, start_data, start_pad, start_fcs,
                                 transmitting, send_error, good_frame_sent, bad_frame_sent}, 0);
        check_eq("rst_frame_len", frame_len, 0);
        reset_n = 1'b1;
        tick();

        run_frame(8, 0, 0, 0, 2, 0);
        repeat (3) tick();
        run_frame(2, 6, 0, 0, 1, 0);
        repeat (3) tick();
        run_frame(3, 0, 3, 0, 0, 0);
        repeat (3) tick();
        run_frame(3, 5, 0, 1, 0, 0);
        repeat (3) tick();

        run_frame(2, 0, 0, 0, 0, 1);
        gap = 1;
        found = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (start_preamble) begin
                found = 1;
                break;
            end
            gap++;
        end
        check_eq("b2b_pre_seen", found, 1);
        check_eq("ifg_gap", gap, IFG_CYCLES + 1);
        run_frame(1, 4, 0, 0, 0, 0);
        repeat (3) tick();

        link_fault = 1'b1;
        tx_start   = 1'b1;
        pre0 = n_pre;
        repeat (10) tick();
        check_eq("lf_no_pre", n_pre - pre0, 0);
        check_eq("lf_idle", transmitting, 0);
        tx_start   = 1'b0;
        link_fault = 1'b0;
        tick();

        tx_start = 1'b1;
        found = 0;
        for (int c = 0; c < 20; c++) begin
            if (start_preamble) begin
                found = 1;
                break;
            end
            tick();
        end
        check_eq("t1_pre_seen", found, 1);
        tx_start = 1'b0;
        tick();
        repeat (3) tick();
        check_eq("t1_in_data", start_data, 1);
        stat0   = n_stat;
        reset_n = 1'b0;
        #1;
        check_eq("t1_rst_outputs", {tx_ack, start_preamble, start_data, start_pad, start_fcs,
                                    transmitting, send_error, good_frame_sent, bad_frame_sent}, 0);
        check_eq("t1_rst_frame_len", frame_len, 0);
        tick();
        reset_n = 1'b1;
        repeat (5) tick();
        check_eq("t1_no_status", n_stat - stat0, 0);
        check_eq("t1_idle", transmitting, 0);

        run_frame(2000, 0, 0, 0, 0, 0);
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
